// File: rtl/iter_pkg.sv
// Shared definitions for the round-robin iterative scheduler: one-hot state
// bit positions, state-vector type and encoded state constants, default width.
package iter_pkg;

  // Bit position of each controller state inside the one-hot state vector.
  localparam int S_IDLE  = 0;
  localparam int S_INIT  = 1;
  localparam int S_ITER  = 2;
  localparam int S_FINAL = 3;

  localparam int ST_W      = 4;
  localparam int CNT_W_DEF = 8;

  typedef logic [ST_W-1:0] state_t;

  // Full one-hot encodings, used when loading the state register.
  localparam state_t ST_IDLE  = state_t'(1 << S_IDLE);
  localparam state_t ST_INIT  = state_t'(1 << S_INIT);
  localparam state_t ST_ITER  = state_t'(1 << S_ITER);
  localparam state_t ST_FINAL = state_t'(1 << S_FINAL);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting one past the
// pointer, wrapping modulo N_REQ, and returns the first hit as one-hot + index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0] win_idx_o
);

  logic found;
  int   pos;

  // Priority scan from ptr+1 around the ring; the first pending request wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[pos]) begin
        found         = 1'b1;
        win_oh_o[pos] = 1'b1;
        win_idx_o     = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/iter_rr_sched.sv
// Round-robin scheduler sharing one iterative down-counter unit among N_REQ
// requesters. One-hot controller IDLE -> INIT -> ITER* -> FINAL -> IDLE.
module iter_rr_sched
  import iter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] cnt_val,
  output logic [N_REQ-1:0]       gnt,
  output logic                   do_iter,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [CNT_W-1:0]       cur_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;

  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   cnt_sel;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  // Select the winner's iteration count; only loaded on the grant edge.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) cnt_sel = cnt_val[i*CNT_W +: CNT_W];
    end
  end

  // Controller, grant, pointer and counter registers in one state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (1'b1)
        state_q[S_IDLE]: begin
          if (|req) begin
            state_q <= ST_INIT;
            gnt_q   <= win_oh;
            idx_q   <= win_idx;
            cnt_q   <= cnt_sel;
          end
        end
        state_q[S_INIT]: begin
          state_q <= (cnt_q == '0) ? ST_FINAL : ST_ITER;
        end
        state_q[S_ITER]: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_FINAL;
        end
        state_q[S_FINAL]: begin
          ptr_q   <= idx_q;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Outputs are registers or direct decodes of state bits; no path from req.
  assign gnt     = gnt_q;
  assign busy    = ~state_q[S_IDLE];
  assign do_iter = state_q[S_ITER];
  assign done    = gnt_q & {N_REQ{state_q[S_FINAL]}};
  assign cur_cnt = cnt_q;

`ifndef SYNTHESIS
  // Simulation guard: the controller must hold exactly one state bit.
  always @(posedge clk) begin
    if (!rst && !$onehot(state_q)) begin
      $display("ERROR: %m state vector %b not one-hot at %0t", state_q, $time);
      $stop;
    end
  end
`endif

endmodule

// File: tb/tb_iter_rr_sched.sv
// Directed testbench for iter_rr_sched: single op, zero count, mid-op changes,
// reset abort, round-robin order and maximum count.
module tb_iter_rr_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] cnt_val;
  logic [N-1:0]   gnt;
  logic           do_iter;
  logic           busy;
  logic [N-1:0]   done;
  logic [W-1:0]   cur_cnt;

  int n_cmp = 0;
  int n_err = 0;

  iter_rr_sched #(
    .N_REQ (N),
    .CNT_W (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cnt_val (cnt_val),
    .gnt     (gnt),
    .do_iter (do_iter),
    .busy    (busy),
    .done    (done),
    .cur_cnt (cur_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".gnt"},     32'(gnt),     32'd0);
    check({tag, ".done"},    32'(done),    32'd0);
    check({tag, ".do_iter"}, 32'(do_iter), 32'd0);
  endtask

  // Called at the negedge of the IDLE cycle t in which req is already driven.
  // At t+1 applies mid_drop / cv_mid, then follows the operation to IDLE.
  task automatic run_op(input string tag, input logic [N-1:0] exp_gnt, input int v,
                        input logic [N-1:0] mid_drop, input logic [N*W-1:0] cv_mid,
                        input bit release_req);
    int pulses;
    bit trace_ok;
    @(negedge clk); // t+1 : INIT
    check({tag, ".gnt"},     32'(gnt),     32'(exp_gnt));
    check({tag, ".busy"},    32'(busy),    32'd1);
    check({tag, ".do_iter"}, 32'(do_iter), 32'd0);
    check({tag, ".init_cnt"}, 32'(cur_cnt), 32'(v));
    req     = req & ~mid_drop;
    cnt_val = cv_mid;
    pulses   = 0;
    trace_ok = 1'b1;
    for (int k = 0; k < v; k++) begin
      @(negedge clk); // t+2+k : ITER
      if (do_iter === 1'b1) pulses++;
      if (cur_cnt !== W'(v - k)) trace_ok = 1'b0;
      if (gnt !== exp_gnt || done !== '0) trace_ok = 1'b0;
    end
    check({tag, ".pulses"}, 32'(pulses), 32'(v));
    check({tag, ".trace"},  32'(trace_ok), 32'd1);
    @(negedge clk); // t+2+v : FINAL
    check({tag, ".done"},      32'(done),    32'(exp_gnt));
    check({tag, ".fin_iter"},  32'(do_iter), 32'd0);
    check({tag, ".fin_gnt"},   32'(gnt),     32'(exp_gnt));
    check({tag, ".fin_cnt"},   32'(cur_cnt), 32'd0);
    if (release_req) req = req & ~exp_gnt;
    @(negedge clk); // t+3+v : IDLE
    check_idle({tag, ".idle"});
  endtask

  logic [N*W-1:0] cv;

  initial begin
    rst     = 1'b1;
    req     = '0;
    cnt_val = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset.cnt", 32'(cur_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Single request, count 5.
    cnt_val[0*W +: W] = 8'd5;
    req = 4'b0001;
    run_op("single", 4'b0001, 5, 4'b0000, cnt_val, 1'b1);

    // Zero count on requester 2: no iterations, done at t+2.
    cnt_val[2*W +: W] = 8'd0;
    req = 4'b0100;
    run_op("zero", 4'b0100, 0, 4'b0000, cnt_val, 1'b1);

    // Requester 1 with count 3; count changed to 9 and req dropped mid-op.
    cnt_val[1*W +: W] = 8'd3;
    req = 4'b0010;
    cv = cnt_val;
    cv[1*W +: W] = 8'd9;
    run_op("midop", 4'b0010, 3, 4'b0010, cv, 1'b0);

    // Reset during ITER while cur_cnt == 4.
    cnt_val[0*W +: W] = 8'd6;
    req = 4'b0001;
    repeat (4) @(negedge clk); // t+1 .. t+4
    check("rstmid.gnt", 32'(gnt), 32'b0001);
    check("rstmid.cnt", 32'(cur_cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("rstmid.gnt0",  32'(gnt),     32'd0);
    check("rstmid.busy0", 32'(busy),    32'd0);
    check("rstmid.iter0", 32'(do_iter), 32'd0);
    check("rstmid.done0", 32'(done),    32'd0);
    check("rstmid.cnt0",  32'(cur_cnt), 32'd0);
    req = '0;
    @(negedge clk);
    check_idle("rstmid.hold");
    rst = 1'b0;

    // Round-robin with all requests held; pointer reset makes 0 first.
    for (int i = 0; i < N; i++) cnt_val[i*W +: W] = 8'd1;
    req = 4'b1111;
    run_op("rr0", 4'b0001, 1, 4'b0000, cnt_val, 1'b0);
    run_op("rr1", 4'b0010, 1, 4'b0000, cnt_val, 1'b0);
    run_op("rr2", 4'b0100, 1, 4'b0000, cnt_val, 1'b0);
    run_op("rr3", 4'b1000, 1, 4'b0000, cnt_val, 1'b0);
    run_op("rr4", 4'b0001, 1, 4'b0000, cnt_val, 1'b1);
    req = '0;
    @(negedge clk);
    check_idle("rr.quiet");

    // Maximum count on requester 3.
    cnt_val[3*W +: W] = 8'd255;
    req = 4'b1000;
    run_op("max", 4'b1000, 255, 4'b0000, cnt_val, 1'b1);
    @(negedge clk);
    check("max.cnt_hold", 32'(cur_cnt), 32'd0);
    check_idle("max.quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
